// File: rtl/mio_bus_responder.sv
// CPU memory/IO bus responder: decodes RAM, switches, LEDs and a free-running counter,
// inserting RAM wait states. Define MIO_BUS_ERR_EN to add the bus_err output.
module mio_bus_responder #(
    parameter int unsigned RAM_WAIT = 2,
    parameter int unsigned RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CPU_MIO,
    input  logic              MemRW,
    input  logic [31:0]       Addr_in,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw,
`ifdef MIO_BUS_ERR_EN
    output logic              bus_err,
`endif
    output logic [15:0]       led
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [3:0] WaitInit = 4'(RAM_WAIT - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [RAM_AW-1:0] ram_idx_q, ram_idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [31:0]       data_in_q, data_in_d;
    logic [15:0]       led_q, led_d;
    logic [31:0]       cnt_q, cnt_d;

    logic [31:0] word_addr;
    logic        hit_ram, hit_sw, hit_led, hit_cnt, hit_none;
    logic [31:0] periph_rdata;

    // Byte lanes are never decoded.
    logic unused_addr;
    assign unused_addr = ^Addr_in[1:0];

    assign word_addr = {Addr_in[31:2], 2'b00};
    assign hit_ram   = (Addr_in[31:28] == 4'h0);
    assign hit_sw    = (word_addr == 32'hE000_0000);
    assign hit_led   = (word_addr == 32'hF000_0000);
    assign hit_cnt   = (word_addr == 32'hF000_0004);
    assign hit_none  = !(hit_ram || hit_sw || hit_led || hit_cnt);

    always_comb begin
        periph_rdata = 32'h0;
        if (hit_sw) begin
            periph_rdata = {16'h0, sw};
        end else if (hit_led) begin
            periph_rdata = {16'h0, led_q};
        end else if (hit_cnt) begin
            periph_rdata = cnt_q;
        end
    end

`ifdef MIO_BUS_ERR_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        ram_idx_d = ram_idx_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        data_in_d = data_in_q;
        led_d     = led_q;
        cnt_d     = cnt_q + 32'd1;
`ifdef MIO_BUS_ERR_EN
        err_d     = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (CPU_MIO) begin
                    ram_idx_d = Addr_in[RAM_AW+1:2];
                    wdata_d   = Data_out;
                    we_d      = MemRW;
                    if (hit_ram) begin
                        state_d = StWait;
                        wcnt_d  = WaitInit;
`ifdef MIO_BUS_ERR_EN
                        err_d   = 1'b0;
`endif
                    end else begin
                        // Peripherals complete on the accept edge itself.
                        state_d = StResp;
`ifdef MIO_BUS_ERR_EN
                        err_d   = hit_none || (hit_sw && MemRW);
`endif
                        if (!MemRW) begin
                            data_in_d = periph_rdata;
                        end else if (hit_led) begin
                            led_d = Data_out[15:0];
                        end else if (hit_cnt) begin
                            cnt_d = Data_out;
                        end
                    end
                end
            end
            StWait: begin
                if (wcnt_q == 4'd0) begin
                    state_d = StResp;
                    if (!we_q) begin
                        data_in_d = ram_dout;
                    end
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wcnt_q    <= 4'd0;
            ram_idx_q <= '0;
            wdata_q   <= 32'h0;
            we_q      <= 1'b0;
            data_in_q <= 32'h0;
            led_q     <= 16'h0;
            cnt_q     <= 32'h0;
`ifdef MIO_BUS_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            ram_idx_q <= ram_idx_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            data_in_q <= data_in_d;
            led_q     <= led_d;
            cnt_q     <= cnt_d;
`ifdef MIO_BUS_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    // In IDLE the RAM sees the live address so its one-cycle read latency overlaps the
    // accept edge; this keeps RAM_WAIT = 1 correct.
    assign ram_addr  = (state_q == StIdle) ? Addr_in[RAM_AW+1:2] : ram_idx_q;
    assign ram_din   = wdata_q;
    assign ram_we    = rst_n && (state_q == StWait) && (wcnt_q == 4'd0) && we_q;
    assign MIO_ready = (state_q == StResp);
    assign Data_in   = data_in_q;
    assign led       = led_q;
`ifdef MIO_BUS_ERR_EN
    assign bus_err   = (state_q == StResp) && err_q;
`endif

endmodule

// File: tb/tb_mio_bus_responder.sv
// Randomized bench for mio_bus_responder against an address-map level reference model.
module tb_mio_bus_responder;

    localparam int unsigned RAM_WAIT = 2;
    localparam int unsigned RAM_AW   = 10;

    logic        clk;
    logic        rst_n;
    logic        CPU_MIO;
    logic        MemRW;
    logic [31:0] Addr_in;
    logic [31:0] Data_out;
    logic [31:0] Data_in;
    logic        MIO_ready;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;
    logic [15:0] sw;
    logic [15:0] led;
`ifdef MIO_BUS_ERR_EN
    logic        bus_err;
`endif

    mio_bus_responder #(
        .RAM_WAIT (RAM_WAIT),
        .RAM_AW   (RAM_AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .CPU_MIO   (CPU_MIO),
        .MemRW     (MemRW),
        .Addr_in   (Addr_in),
        .Data_out  (Data_out),
        .Data_in   (Data_in),
        .MIO_ready (MIO_ready),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .sw        (sw),
`ifdef MIO_BUS_ERR_EN
        .bus_err   (bus_err),
`endif
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External synchronous RAM.
    logic [31:0] mem [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int unsigned cyc;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    logic [31:0] ref_mem [0:(1<<RAM_AW)-1];
    logic [31:0] ref_data_in;
    logic [15:0] ref_led;
    logic [31:0] cnt_base;
    int unsigned cnt_base_edge;

    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // 0 ram, 1 sw, 2 led, 3 cnt, 4 unmapped
    function automatic int target_of(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (a[31:28] == 4'h0) return 0;
        if (w == 32'hE000_0000) return 1;
        if (w == 32'hF000_0000) return 2;
        if (w == 32'hF000_0004) return 3;
        return 4;
    endfunction

    function automatic logic [31:0] cnt_at(input int unsigned edge_idx);
        return cnt_base + 32'(edge_idx - cnt_base_edge);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        CPU_MIO = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n         = 1'b1;
        cnt_base      = 32'h0;
        cnt_base_edge = cyc + 1;
        ref_data_in   = 32'h0;
        ref_led       = 16'h0;
    endtask

    // Issue one request from an idle bus and check the full response.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [15:0] swv, input string tag);
        int unsigned acc;
        int tgt;
        int n;
        int we_cnt;
        int exp_lat;
        logic [31:0] we_addr;
        logic [31:0] we_din;
        logic err_seen;
        sw       = swv;
        CPU_MIO  = 1'b1;
        MemRW    = we;
        Addr_in  = addr;
        Data_out = wdata;
        acc      = cyc + 1;
        tgt      = target_of(addr);
        exp_lat  = (tgt == 0) ? int'(RAM_WAIT) + 1 : 1;
        if (!we) begin
            case (tgt)
                0: ref_data_in = ref_mem[addr[RAM_AW+1:2]];
                1: ref_data_in = {16'h0, swv};
                2: ref_data_in = {16'h0, ref_led};
                3: ref_data_in = cnt_at(acc);
                default: ref_data_in = 32'h0;
            endcase
        end else begin
            case (tgt)
                0: ref_mem[addr[RAM_AW+1:2]] = wdata;
                2: ref_led = wdata[15:0];
                3: begin
                    cnt_base      = wdata;
                    cnt_base_edge = acc + 1;
                end
                default: ;
            endcase
        end
        n = 0;
        we_cnt = 0;
        we_addr = 32'h0;
        we_din = 32'h0;
        err_seen = 1'b0;
        while (1) begin
            @(negedge clk);
            n++;
            if (ram_we) begin
                we_cnt++;
                we_addr = 32'(ram_addr);
                we_din  = ram_din;
            end
            if (MIO_ready) begin
`ifdef MIO_BUS_ERR_EN
                err_seen = bus_err;
`endif
                break;
            end
            if (n > 40) begin
                chk({tag, "/timeout"}, 32'(n), 32'(exp_lat));
                break;
            end
        end
        CPU_MIO = 1'b0;
        chk({tag, "/latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "/data_in"}, Data_in, ref_data_in);
        chk({tag, "/led"}, {16'h0, led}, {16'h0, ref_led});
        chk({tag, "/we_count"}, 32'(we_cnt), (tgt == 0 && we) ? 32'd1 : 32'd0);
        if (tgt == 0 && we) begin
            chk({tag, "/ram_addr"}, we_addr, 32'(addr[RAM_AW+1:2]));
            chk({tag, "/ram_din"}, we_din, wdata);
        end
`ifdef MIO_BUS_ERR_EN
        chk({tag, "/bus_err"}, {31'h0, err_seen}, {31'h0, (tgt == 4) || (tgt == 1 && we)});
`else
        chk({tag, "/bus_err"}, {31'h0, err_seen}, 32'h0);
`endif
        @(negedge clk);
        chk({tag, "/ready_pulse"}, {31'h0, MIO_ready}, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr(input int kind);
        logic [31:0] a;
        case (kind)
            0: a = {4'h0, 28'($urandom)};
            1: a = 32'hE000_0000 | 32'($urandom_range(0, 3));
            2: a = 32'hF000_0000 | 32'($urandom_range(0, 3));
            3: a = 32'hF000_0004 | 32'($urandom_range(0, 3));
            default: begin
                a = $urandom;
                for (int k = 0; k < 16 && target_of(a) != 4; k++) a = $urandom;
                if (target_of(a) != 4) a = 32'h8000_0000;
            end
        endcase
        return a;
    endfunction

    initial begin
        int pulses;
        int prev;
        int saw_we;
        int saw_rdy;
        logic [31:0] a;
        logic w;
        total = 0;
        bad = 0;
        for (int i = 0; i < (1 << RAM_AW); i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst_n = 1'b0;
        CPU_MIO = 1'b0;
        MemRW = 1'b0;
        Addr_in = 32'h0;
        Data_out = 32'h0;
        sw = 16'h0;

        do_reset();
        chk("rst/ready", {31'h0, MIO_ready}, 32'h0);
        chk("rst/data_in", Data_in, 32'h0);
        chk("rst/led", {16'h0, led}, 32'h0);
        chk("rst/ram_we", {31'h0, ram_we}, 32'h0);

        do_req(1'b1, 32'h0000_0010, 32'h1234_5678, 16'h0, "ram_wr");
        do_req(1'b0, 32'h0000_0010, 32'h0, 16'h0, "ram_rd");
        do_req(1'b0, 32'hE000_0000, 32'h0, 16'hA5A5, "sw_rd");
        do_req(1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 16'hA5A5, "led_wr");
        do_req(1'b1, 32'hE000_0000, 32'hDEAD_BEEF, 16'h1111, "sw_wr");
        do_req(1'b0, 32'hF000_0000, 32'h0, 16'h0, "led_rd");
        do_req(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 16'h0, "cnt_wr");
        do_req(1'b0, 32'hF000_0004, 32'h0, 16'h0, "cnt_rd0");
        do_req(1'b0, 32'hF000_0004, 32'h0, 16'h0, "cnt_rd1");

        // Three back-to-back reads with the strobe held high.
        @(negedge clk);
        sw = 16'h3C3C;
        Addr_in = 32'hE000_0000;
        MemRW = 1'b0;
        CPU_MIO = 1'b1;
        pulses = 0;
        prev = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (MIO_ready) begin
                pulses++;
                chk("b2b/data_in", Data_in, 32'h0000_3C3C);
                if (pulses > 1) chk("b2b/gap", 32'(i - prev), 32'd2);
                prev = i;
                if (pulses == 3) CPU_MIO = 1'b0;
            end
        end
        chk("b2b/count", 32'(pulses), 32'd3);
        ref_data_in = 32'h0000_3C3C;

        // Reset during the wait of a RAM write must drop it.
        do_req(1'b1, 32'h0000_001C, 32'hAAAA_AAAA, 16'h0, "ram_wr7");
        MemRW = 1'b1;
        Addr_in = 32'h0000_001C;
        Data_out = 32'h5555_5555;
        CPU_MIO = 1'b1;
        @(negedge clk);
        saw_we = ram_we ? 1 : 0;
        saw_rdy = MIO_ready ? 1 : 0;
        rst_n = 1'b0;
        CPU_MIO = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt_base = 32'h0;
        cnt_base_edge = cyc + 1;
        ref_data_in = 32'h0;
        ref_led = 16'h0;
        for (int i = 0; i < 5; i++) begin
            if (ram_we) saw_we++;
            if (MIO_ready) saw_rdy++;
            @(negedge clk);
        end
        chk("rstwait/ram_we", 32'(saw_we), 32'd0);
        chk("rstwait/ready", 32'(saw_rdy), 32'd0);
        chk("rstwait/data_in", Data_in, 32'h0);
        chk("rstwait/led", {16'h0, led}, 32'h0);
        do_req(1'b0, 32'h0000_001C, 32'h0, 16'h0, "ram_rd7");
        do_req(1'b0, 32'h8000_0000, 32'h0, 16'h0, "unmapped_rd");
        do_req(1'b0, 32'hF000_0004, 32'h0, 16'h0, "cnt_after_rst");

        for (int i = 0; i < 150; i++) begin
            int kind;
            kind = $urandom_range(0, 4);
            a = rand_addr(kind);
            w = 1'($urandom);
            do_req(w, a, $urandom, 16'($urandom), "rand");
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
